// File: rtl/sparse_weight_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : sparse_weight_packer_if
// Purpose  : Bundles the dense-tile input handshake and the sparse memory
//            write bus of the sparse weight packer.
// Ports    : tile_valid/tile_ready/w_in  - dense tile handshake
//            addr_clear                  - tile address counter clear
//            wr_valid/wr_ready/wr_*      - per-slot weight/index write
//            tile_done, nnz_count        - per-tile status
//            master modport = packer side, slave modport = environment side
// Revision : 1.0 - initial release
// ============================================================================
interface sparse_weight_packer_if #(
    parameter int DATA_W        = 16,
    parameter int N_ROWS        = 4,
    parameter int N_COLS        = 4,
    parameter int WEIGHT_ADDR_W = 12,
    parameter int INDEX_ADDR_W  = 10
);
    localparam int IN_SIZE  = N_ROWS * N_COLS;
    localparam int IDX_BITS = (IN_SIZE <= 1) ? 1 : $clog2(IN_SIZE);

    logic                      tile_valid;
    logic                      tile_ready;
    logic [IN_SIZE*DATA_W-1:0] w_in;
    logic                      addr_clear;
    logic                      wr_valid;
    logic                      wr_ready;
    logic [WEIGHT_ADDR_W-1:0]  wr_tile_addr;
    logic [IDX_BITS-1:0]       wr_slot;
    logic [DATA_W-1:0]         wr_weight;
    logic [INDEX_ADDR_W-1:0]   wr_index;
    logic                      tile_done;
    logic [IDX_BITS:0]         nnz_count;

    modport master (
        input  tile_valid, w_in, addr_clear, wr_ready,
        output tile_ready, wr_valid, wr_tile_addr, wr_slot, wr_weight,
               wr_index, tile_done, nnz_count
    );

    modport slave (
        output tile_valid, w_in, addr_clear, wr_ready,
        input  tile_ready, wr_valid, wr_tile_addr, wr_slot, wr_weight,
               wr_index, tile_done, nnz_count
    );
endinterface
`default_nettype wire

// File: rtl/sparse_weight_packer.sv
`default_nettype none
// ============================================================================
// Module   : sparse_weight_packer
// Purpose  : Compresses one dense N_ROWS x N_COLS weight tile into the
//            nonzero-list format (H[k] weights + packed S[k] index words).
//            Nonzeros are emitted first in ascending element order, then
//            disabled padding entries, so every tile fills IN_SIZE slots.
// Ports    : clk    - clock
//            rst_n  - asynchronous active-low reset
//            bus    - sparse_weight_packer_if.master (tile in, writes out)
// Revision : 1.0 - initial release
// ============================================================================
module sparse_weight_packer #(
    parameter int DATA_W        = 16,
    parameter int N_ROWS        = 4,
    parameter int N_COLS        = 4,
    parameter int WEIGHT_ADDR_W = 12,
    parameter int INDEX_ADDR_W  = 10
) (
    input  wire                    clk,
    input  wire                    rst_n,
    sparse_weight_packer_if.master bus
);
    localparam int IN_SIZE  = N_ROWS * N_COLS;
    localparam int IDX_BITS = (IN_SIZE <= 1) ? 1 : $clog2(IN_SIZE);

    // The index word must hold enable + dest + src fields.
    generate
        if (INDEX_ADDR_W < 2 * IDX_BITS + 1) begin : g_bad_index_width
            $error("sparse_weight_packer: INDEX_ADDR_W must be >= 2*IDX_BITS+1");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [IN_SIZE*DATA_W-1:0] r_tile;
    logic [IN_SIZE-1:0]        r_mask;       // nonzero elements not yet emitted
    logic [IDX_BITS-1:0]       r_slot;
    logic [WEIGHT_ADDR_W-1:0]  r_tile_addr;
    logic [IDX_BITS:0]         r_nnz;
    logic                      r_done;

    logic                      w_tile_ready;
    logic                      w_wr_valid;
    logic [IN_SIZE-1:0]        w_new_mask;
    logic [IDX_BITS:0]         w_new_nnz;
    logic                      w_found;
    logic [IDX_BITS-1:0]       w_pos;
    logic [DATA_W-1:0]         w_weight;
    logic [INDEX_ADDR_W-1:0]   w_index;
    logic                      w_accept;
    logic                      w_fire;
    logic                      w_last;

    assign w_accept = (r_state == S_IDLE) && bus.tile_valid;
    assign w_fire   = (r_state == S_EMIT) && bus.wr_ready;
    assign w_last   = (r_slot == IDX_BITS'(IN_SIZE - 1));

    // Nonzero mask and population count of the incoming tile.
    always_comb begin
        w_new_mask = '0;
        w_new_nnz  = '0;
        for (int k = 0; k < IN_SIZE; k++) begin
            w_new_mask[k] = (bus.w_in[k*DATA_W +: DATA_W] != '0);
            w_new_nnz     = w_new_nnz + (IDX_BITS+1)'(w_new_mask[k]);
        end
    end

    // Lowest pending nonzero: scanning downward lets the smallest index win.
    always_comb begin
        w_found = 1'b0;
        w_pos   = '0;
        for (int k = IN_SIZE - 1; k >= 0; k--) begin
            if (r_mask[k]) begin
                w_found = 1'b1;
                w_pos   = IDX_BITS'(k);
            end
        end
    end

    // Entry payload; an empty mask yields a disabled all-zero padding entry.
    always_comb begin
        w_weight = '0;
        w_index  = '0;
        if ((r_state == S_EMIT) && w_found) begin
            w_weight                             = r_tile[w_pos*DATA_W +: DATA_W];
            w_index[INDEX_ADDR_W-1]              = 1'b1;
            w_index[2*IDX_BITS-1:IDX_BITS]       = w_pos;
            w_index[IDX_BITS-1:0]                = w_pos;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and handshake outputs.
    always_comb begin
        w_state_nxt  = r_state;
        w_tile_ready = 1'b0;
        w_wr_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tile_ready = 1'b1;
                if (bus.tile_valid) begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                w_wr_valid = 1'b1;
                if (bus.wr_ready && w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: everything visible on wr_* only moves on accept or handshake,
    // which keeps the write bus stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tile      <= '0;
            r_mask      <= '0;
            r_slot      <= '0;
            r_tile_addr <= '0;
            r_nnz       <= '0;
            r_done      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tile <= bus.w_in;
                r_mask <= w_new_mask;
                r_nnz  <= w_new_nnz;
                r_slot <= '0;
            end else if (w_fire) begin
                if (w_found) begin
                    r_mask[w_pos] <= 1'b0;
                end
                r_slot <= w_last ? '0 : r_slot + IDX_BITS'(1);
            end

            r_done <= w_fire && w_last;

            // Clear has priority over the end-of-tile increment.
            if (bus.addr_clear) begin
                r_tile_addr <= '0;
            end else if (w_fire && w_last) begin
                r_tile_addr <= r_tile_addr + WEIGHT_ADDR_W'(1);
            end
        end
    end

    assign bus.tile_ready   = w_tile_ready;
    assign bus.wr_valid     = w_wr_valid;
    assign bus.wr_tile_addr = r_tile_addr;
    assign bus.wr_slot      = r_slot;
    assign bus.wr_weight    = w_weight;
    assign bus.wr_index     = w_index;
    assign bus.tile_done    = r_done;
    assign bus.nnz_count    = r_nnz;

endmodule
`default_nettype wire

// File: tb/tb_sparse_weight_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sparse_weight_packer
// Purpose  : Self-checking bench for sparse_weight_packer. A tile-level
//            reference model (nonzero list + padding, address counter)
//            predicts every cycle of the write bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sparse_weight_packer;
    localparam int DW  = 16;
    localparam int NR  = 4;
    localparam int NC  = 4;
    localparam int AW  = 2;
    localparam int IAW = 10;
    localparam int IN  = NR * NC;
    localparam int IB  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sparse_weight_packer_if #(
        .DATA_W(DW), .N_ROWS(NR), .N_COLS(NC), .WEIGHT_ADDR_W(AW), .INDEX_ADDR_W(IAW)
    ) bus ();

    sparse_weight_packer #(
        .DATA_W(DW), .N_ROWS(NR), .N_COLS(NC), .WEIGHT_ADDR_W(AW), .INDEX_ADDR_W(IAW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state (values valid for the cycle about to be checked)
    bit          m_emit = 1'b0;
    int          m_slot = 0;
    int          m_addr = 0;
    int          m_nnz  = 0;
    bit          m_done = 1'b0;
    logic [31:0] exp_w [IN];
    logic [31:0] exp_i [IN];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Nonzero list in ascending element order, padding entries after it.
    task automatic model_accept(input logic [IN*DW-1:0] t);
        int n = 0;
        for (int k = 0; k < IN; k++) begin
            exp_w[k] = '0;
            exp_i[k] = '0;
        end
        for (int k = 0; k < IN; k++) begin
            if (t[k*DW +: DW] != '0) begin
                exp_w[n] = 32'(t[k*DW +: DW]);
                exp_i[n] = (32'd1 << (IAW - 1)) | (32'(k) << IB) | 32'(k);
                n++;
            end
        end
        m_nnz  = n;
        m_slot = 0;
        m_emit = 1'b1;
    endtask

    function automatic logic [IN*DW-1:0] rand_tile(input int dens);
        logic [IN*DW-1:0] t;
        for (int k = 0; k < IN; k++) begin
            t[k*DW +: DW] = ($urandom_range(0, 99) < dens) ? DW'($urandom) : '0;
        end
        return t;
    endfunction

    task automatic check_reset_vals();
        check("rst_tile_ready", 32'(bus.tile_ready), 32'd1);
        check("rst_wr_valid",   32'(bus.wr_valid),   32'd0);
        check("rst_tile_done",  32'(bus.tile_done),  32'd0);
        check("rst_addr",       32'(bus.wr_tile_addr), 32'd0);
        check("rst_slot",       32'(bus.wr_slot),    32'd0);
        check("rst_weight",     32'(bus.wr_weight),  32'd0);
        check("rst_index",      32'(bus.wr_index),   32'd0);
        check("rst_nnz",        32'(bus.nnz_count),  32'd0);
    endtask

    // One clock: drive inputs, check outputs, advance the model over the edge.
    task automatic tick(input bit tv, input logic [IN*DW-1:0] tl, input bit rdy, input bit clr);
        bit nd = 1'b0;
        @(negedge clk);
        bus.tile_valid = tv;
        bus.w_in       = tl;
        bus.wr_ready   = rdy;
        bus.addr_clear = clr;
        #1;
        check("tile_ready", 32'(bus.tile_ready), 32'(!m_emit));
        check("wr_valid",   32'(bus.wr_valid),   32'(m_emit));
        check("tile_done",  32'(bus.tile_done),  32'(m_done));
        check("nnz_count",  32'(bus.nnz_count),  32'(m_nnz));
        check("tile_addr",  32'(bus.wr_tile_addr), 32'(m_addr));
        if (m_emit) begin
            check("wr_slot",   32'(bus.wr_slot),   32'(m_slot));
            check("wr_weight", 32'(bus.wr_weight), exp_w[m_slot]);
            check("wr_index",  32'(bus.wr_index),  exp_i[m_slot]);
        end
        if (!m_emit) begin
            if (tv) model_accept(tl);
        end else if (rdy) begin
            if (m_slot == IN - 1) begin
                m_emit = 1'b0;
                nd     = 1'b1;
                m_slot = 0;
                m_addr = (m_addr + 1) % (1 << AW);
            end else begin
                m_slot++;
            end
        end
        if (clr) m_addr = 0;
        m_done = nd;
    endtask

    task automatic do_reset_mid();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        m_emit = 1'b0; m_slot = 0; m_addr = 0; m_nnz = 0; m_done = 1'b0;
        @(negedge clk);
        bus.tile_valid = 1'b0;
        bus.wr_ready   = 1'b0;
        bus.addr_clear = 1'b0;
        rst_n = 1'b1;
    endtask

    // Send one tile and follow it to completion. rnd enables random
    // backpressure, idle gaps, tile_valid noise and addr_clear.
    task automatic run_tile(input logic [IN*DW-1:0] t, input int stall_slot, input int stall_len,
                            input bit clr_last, input bit rnd, input int rst_slot);
        int  guard  = 0;
        int  stalls = 0;
        bit  rdy;
        bit  clr;
        if (rnd) begin
            repeat ($urandom_range(0, 2)) tick(1'b0, rand_tile(50), 1'b1, ($urandom_range(0, 7) == 0));
        end
        tick(1'b1, t, 1'b1, rnd && ($urandom_range(0, 7) == 0));
        while (m_emit && guard < 400) begin
            guard++;
            if (rst_slot >= 0 && m_slot == rst_slot) begin
                do_reset_mid();
                return;
            end
            rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (m_slot == stall_slot && stalls < stall_len) begin
                rdy = 1'b0;
                stalls++;
            end
            clr = rnd && ($urandom_range(0, 15) == 0);
            if (clr_last && m_slot == IN - 1 && rdy) clr = 1'b1;
            tick(1'($urandom_range(0, 1)), rand_tile(60), rdy, clr);
        end
        if (m_emit) check("tile_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        logic [IN*DW-1:0] t;
        bus.tile_valid = 1'b0;
        bus.w_in       = '0;
        bus.wr_ready   = 1'b0;
        bus.addr_clear = 1'b0;
        for (int k = 0; k < IN; k++) begin
            exp_w[k] = '0;
            exp_i[k] = '0;
        end

        @(negedge clk);
        #1;
        check_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;

        // Fully dense tile w[k] = k+1
        for (int k = 0; k < IN; k++) t[k*DW +: DW] = DW'(k + 1);
        run_tile(t, -1, 0, 1'b0, 1'b0, -1);

        // Sparse tile: w[3] = -5, w[10] = 7
        t = '0;
        t[3*DW +: DW]  = 16'hFFFB;
        t[10*DW +: DW] = 16'd7;
        run_tile(t, -1, 0, 1'b0, 1'b0, -1);

        // All-zero tile
        run_tile('0, -1, 0, 1'b0, 1'b0, -1);

        // Five cycles of backpressure at slot 2
        run_tile(rand_tile(50), 2, 5, 1'b0, 1'b0, -1);

        // Advance to address 3, then reset after slot 6 has been written
        repeat (3) run_tile(rand_tile(40), -1, 0, 1'b0, 1'b0, -1);
        check("addr_before_rst", 32'(m_addr), 32'd3);
        run_tile(rand_tile(70), -1, 0, 1'b0, 1'b0, 7);
        run_tile(rand_tile(70), -1, 0, 1'b0, 1'b0, -1);

        // Clear, then five back-to-back tiles: addresses 0,1,2,3,0
        tick(1'b0, '0, 1'b1, 1'b1);
        repeat (5) run_tile(rand_tile(50), -1, 0, 1'b0, 1'b0, -1);

        // addr_clear coinciding with the last slot of a tile wins over increment
        run_tile(rand_tile(50), -1, 0, 1'b1, 1'b0, -1);
        run_tile(rand_tile(50), -1, 0, 1'b0, 1'b0, -1);

        // Randomized traffic
        for (int i = 0; i < 25; i++) begin
            run_tile(rand_tile($urandom_range(0, 100)), -1, 0, 1'b0, 1'b1, -1);
        end
        tick(1'b0, '0, 1'b1, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
